// File: rtl/cla_pipe_adder_pkg.sv
// Shared defaults and elaboration helpers for the pipelined CLA adder.
package adder_pkg;
  localparam int WIDTH_D = 32;
  localparam int BLK_D   = 4;
  localparam int GPS_D   = 2;

  function automatic int nstage(input int width, input int blk, input int gps);
    return width / (blk * gps);
  endfunction

  function automatic bit cfg_ok(input int width, input int blk, input int gps);
    return (blk > 0) && (gps > 0) && (width > 0) && ((width % (blk * gps)) == 0);
  endfunction
endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if #(parameter int WIDTH = adder_pkg::WIDTH_D);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             c_in, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out, ovf;

  modport master (output in_valid, a, b, c_in, sub, out_ready,
                  input  in_ready, out_valid, sum, c_out, ovf);
  modport slave  (input  in_valid, a, b, c_in, sub, out_ready,
                  output in_ready, out_valid, sum, c_out, ovf);
endinterface

// File: rtl/cla_pipe_adder_group.sv
// One BLK-bit carry-lookahead group: sum, group G/P and carry into its MSB.
module cla_group #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           c_i,
  output logic [BLK-1:0] s_o,
  output logic           g_o,
  output logic           p_o,
  output logic           c_msb_o
);
  logic [BLK-1:0] g, p, c;
  logic [BLK:1]   gg, pp;
  logic           t;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // gg[i]/pp[i]: generate/propagate of bits [i-1:0], flattened sum-of-products
  always_comb begin
    gg = '0;
    pp = '0;
    t  = 1'b0;
    for (int i = 1; i <= BLK; i++) begin
      pp[i] = 1'b1;
      for (int k = 0; k < i; k++) pp[i] = pp[i] & p[k];
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        gg[i] = gg[i] | t;
      end
    end
  end

  // Kept apart from the G/P block so c_i never sits on the G/P path
  always_comb begin
    c    = '0;
    c[0] = c_i;
    for (int i = 1; i < BLK; i++) c[i] = gg[i] | (pp[i] & c_i);
  end

  assign s_o     = p ^ c;
  assign g_o     = gg[BLK];
  assign p_o     = pp[BLK];
  assign c_msb_o = c[BLK-1];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: GPS groups per stage, registered inter-stage carry,
// per-stage valid/ready with bubble collapse.
module cla_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int BLK   = BLK_D,
  parameter int GPS   = GPS_D
) (
  input logic             clk,
  input logic             rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int SW     = BLK * GPS;
  localparam int NSTAGE = nstage(WIDTH, BLK, GPS);

  if (!cfg_ok(WIDTH, BLK, GPS)) begin : g_cfg_err
    $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK*GPS");
  end

  logic [NSTAGE-1:0] vld_q, vin, rdy;

  // rdy[s] = !v[s] || rdy[s+1] unrolled, so no bit depends on another bit of rdy
  for (genvar s = 0; s < NSTAGE; s++) begin : g_rdy
    assign rdy[s] = bus.out_ready | ~(&vld_q[NSTAGE-1:s]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_q <= '0;
    else
      for (int s = 0; s < NSTAGE; s++)
        if (rdy[s]) vld_q[s] <= vin[s];

  for (genvar s = 0; s < NSTAGE; s++) begin : st
    localparam int RW = WIDTH - s * SW;

    logic [RW-1:0]         a_in, b_in;
    logic                  cin;
    logic [SW-1:0]         chunk;
    logic [GPS-1:0]        gg, pp, cm;
    logic [GPS:0]          gc;
    logic [(s+1)*SW-1:0]   sum_d, sum_q;
    logic                  c_q;
    logic                  t, acc;
    logic                  cm_unused;

    if (s == 0) begin : src
      assign a_in   = bus.a;
      assign b_in   = bus.b ^ {WIDTH{bus.sub}};
      assign cin    = bus.sub | bus.c_in;
      assign vin[s] = bus.in_valid;
      assign sum_d  = chunk;
    end else begin : src
      assign a_in   = st[s-1].opr.a_q;
      assign b_in   = st[s-1].opr.b_q;
      assign cin    = st[s-1].c_q;
      assign vin[s] = vld_q[s-1];
      assign sum_d  = {chunk, st[s-1].sum_q};
    end

    for (genvar k = 0; k < GPS; k++) begin : grp
      cla_group #(.BLK(BLK)) u_grp (
        .a_i     (a_in[k*BLK +: BLK]),
        .b_i     (b_in[k*BLK +: BLK]),
        .c_i     (gc[k]),
        .s_o     (chunk[k*BLK +: BLK]),
        .g_o     (gg[k]),
        .p_o     (pp[k]),
        .c_msb_o (cm[k])
      );
    end

    // Second lookahead level across the stage's groups
    always_comb begin
      gc    = '0;
      gc[0] = cin;
      t     = 1'b0;
      acc   = 1'b0;
      for (int k = 1; k <= GPS; k++) begin
        acc = cin;
        for (int j = 0; j < k; j++) acc = acc & pp[j];
        for (int j = 0; j < k; j++) begin
          t = gg[j];
          for (int m = j + 1; m < k; m++) t = t & pp[m];
          acc = acc | t;
        end
        gc[k] = acc;
      end
    end

    assign cm_unused = ^cm;

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (rdy[s]) begin
        sum_q <= sum_d;
        c_q   <= gc[GPS];
      end

    if (s < NSTAGE - 1) begin : opr
      logic [RW-SW-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[s]) begin
          a_q <= a_in[RW-1:SW];
          b_q <= b_in[RW-1:SW];
        end
    end

    if (s == NSTAGE - 1) begin : fin
      logic cmsb_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      cmsb_q <= 1'b0;
        else if (rdy[s]) cmsb_q <= cm[GPS-1];
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_q[NSTAGE-1];
  assign bus.sum       = st[NSTAGE-1].sum_q;
  assign bus.c_out     = st[NSTAGE-1].c_q;
  assign bus.ovf       = st[NSTAGE-1].fin.cmsb_q ^ st[NSTAGE-1].c_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed checks of cla_pipe_adder: arithmetic corners, backpressure, mid-stream
// reset, and three non-default parameter sets against a behavioural '+'.
module tb_cla_pipe_adder;
  typedef logic [63:0] u64;

  logic clk, rst_n, sw_rst_n;
  int   n_chk, n_fail, sw_done;

  cla_pipe_adder_if #(.WIDTH(32)) bus ();
  cla_pipe_adder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input u64 got, input u64 exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, input logic [31:0] es,
                        input logic ec, input logic eo);
    int e;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.c_in = ci; bus.sub = sb;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 chk({tag, "_inrdy"}, u64'(bus.in_ready), 64'd1);
    @(posedge clk);
    e = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && e < 20) begin
      @(posedge clk); e++; @(negedge clk);
    end
    chk({tag, "_lat"}, u64'(e), 64'd4);
    chk({tag, "_sum"}, u64'(bus.sum), u64'(es));
    chk({tag, "_cout"}, u64'(bus.c_out), u64'(ec));
    chk({tag, "_ovf"}, u64'(bus.ovf), u64'(eo));
  endtask

  // Parameter sweep: W/BLK/GPS and hand-derived latency per instance
  initial begin
    sw_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) sw_rst_n = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W   = (g == 0) ? 16 : (g == 1) ? 8 : 64;
    localparam int BK  = (g == 2) ? 8 : 4;
    localparam int GP  = (g == 0) ? 1 : 2;
    localparam int LAT = (g == 1) ? 1 : 4;
    localparam int W1  = W + 1;

    cla_pipe_adder_if #(.WIDTH(W)) ifc ();
    cla_pipe_adder #(.WIDTH(W), .BLK(BK), .GPS(GP)) dut (.clk(clk), .rst_n(sw_rst_n), .bus(ifc));

    initial begin
      logic [W:0]   exp_q[$];
      logic         ovf_q[$];
      int           cyc_q[$];
      logic [63:0]  r;
      logic [W-1:0] ra, rb, bb;
      logic         ci, sb;
      logic [W:0]   e;
      int           cyc;
      string        tag;
      tag = $sformatf("sweep%0d", g);
      ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.c_in = 1'b0; ifc.sub = 1'b0;
      ifc.out_ready = 1'b1;
      repeat (6) @(negedge clk);
      cyc = 0;
      for (int n = 0; n < 40; n++) begin
        if (ifc.out_valid) begin
          if (exp_q.size() == 0) chk({tag, "_spurious"}, u64'(ifc.out_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, u64'(ifc.sum), u64'(e[W-1:0]));
            chk({tag, "_cout"}, u64'(ifc.c_out), u64'(e[W]));
            chk({tag, "_ovf"}, u64'(ifc.ovf), u64'(ovf_q.pop_front()));
            chk({tag, "_lat"}, u64'(cyc - cyc_q.pop_front()), u64'(LAT));
          end
        end
        if (n < 24) begin
          r  = {$urandom, $urandom}; ra = r[W-1:0];
          r  = {$urandom, $urandom}; rb = r[W-1:0];
          ci = 1'($urandom_range(0, 1));
          sb = 1'($urandom_range(0, 1));
          bb = sb ? ~rb : rb;
          e  = {1'b0, ra} + {1'b0, bb} + W1'(sb | ci);
          ifc.a = ra; ifc.b = rb; ifc.c_in = ci; ifc.sub = sb; ifc.in_valid = 1'b1;
          if (ifc.in_ready) begin
            exp_q.push_back(e);
            ovf_q.push_back((ra[W-1] == bb[W-1]) && (e[W-1] != ra[W-1]));
            cyc_q.push_back(cyc);
          end
        end else ifc.in_valid = 1'b0;
        @(posedge clk); cyc++; @(negedge clk);
      end
      chk({tag, "_left"}, u64'(exp_q.size()), 64'd0);
      sw_done++;
    end
  end

  initial begin
    int   sent, got, stall, cnt;
    logic seen, hold_v;
    logic [31:0] held;
    n_chk = 0; n_fail = 0; sw_done = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", u64'(bus.out_valid), 64'd0);
    chk("rst_sum", u64'(bus.sum), 64'd0);
    chk("rst_cout", u64'(bus.c_out), 64'd0);
    chk("rst_ovf", u64'(bus.ovf), 64'd0);
    chk("rst_inrdy_or0", u64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    #1 chk("rst_inrdy_or1", u64'(bus.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;

    run_op("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub57", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("ovfp",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("cin",   32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);
    run_op("ovfn",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("subeq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: 8 ops a=b=i, consumer stalls 3 cycles once the first result shows
    sent = 0; got = 0; stall = 0; seen = 1'b0; hold_v = 1'b0; held = '0;
    bus.c_in = 1'b0; bus.sub = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && !seen) begin seen = 1'b1; stall = 3; end
      bus.out_ready = (stall == 0);
      #1;
      if (hold_v) begin
        chk("bp_vld_hold", u64'(bus.out_valid), 64'd1);
        chk("bp_sum_hold", u64'(bus.sum), u64'(held));
      end
      if (stall > 0) begin
        if (sent - got == 4) chk("bp_full_inrdy", u64'(bus.in_ready), 64'd0);
        held = bus.sum; hold_v = 1'b1; stall--;
      end else if (hold_v) begin
        chk("bp_release_inrdy", u64'(bus.in_ready), 64'd1);
        hold_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_order", u64'(bus.sum), u64'(2 * got));
        got++;
      end
      if (sent < 8) begin
        bus.in_valid = 1'b1; bus.a = 32'(sent); bus.b = 32'(sent);
        if (bus.in_ready) sent++;
      end else bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bp_stalled", u64'(seen), 64'd1);
    chk("bp_count", u64'(got), 64'd8);
    repeat (2) @(negedge clk);
    chk("bp_no_dup", u64'(bus.out_valid), 64'd0);

    // Reset with three ops in flight, the oldest already presented
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.a = 32'(100 + i); bus.b = '0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_pre_vld", u64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", u64'(bus.out_valid), 64'd0);
    chk("mrst_sum", u64'(bus.sum), 64'd0);
    chk("mrst_inrdy", u64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("mrst_no_stale", u64'(cnt), 64'd0);
    chk("mrst_inrdy_after", u64'(bus.in_ready), 64'd1);
    run_op("recov", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    for (int i = 0; i < 2000 && sw_done < 3; i++) @(negedge clk);
    chk("sweep_done", u64'(sw_done), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. Operand width is split into CLA groups of `BLK` bits. `GPS` groups are resolved per pipeline stage, and the inter-stage carry is registered, so throughput is one operation per cycle with fixed latency. It generalises the fixed 16-bit rippled 4-bit CLA into a datapath-width-agnostic, backpressure-aware unit for the ALU and address paths.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of `BLK*GPS`
- `BLK`, 4, bits per CLA group
- `GPS`, 2, CLA groups per pipeline stage; `NSTAGE = WIDTH/(BLK*GPS)`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands present
- `in_ready`  out  1  unit can accept this cycle
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B
- `c_in`  in  1  carry-in; ignored when `sub=1`
- `sub`  in  1  0: A+B+c_in; 1: A+~B+1
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `sum`  out  WIDTH  result
- `c_out`  out  1  carry out of MSB; in subtract mode, 1 = no borrow
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- Accept on an edge with `in_valid && in_ready`. Stage 0 inverts B when `sub=1`, then uses carry-in `sub ? 1 : c_in`.
- Stage s (0..NSTAGE-1) resolves groups s*GPS .. s*GPS+GPS-1 using the registered carry from stage s-1, or the initial carry for s=0.
- Each stage register holds:
  - valid bit
  - sum bits resolved so far
  - unconsumed upper operand bits (B already conditioned)
  - carry into the next stage
  - carry into the MSB, final stage only
- Within a stage, groups use group generate/propagate lookahead. Group carries within the stage are computed from G/P, not rippled bit-by-bit.
- Flow control per stage: `rdy[s] = !v[s] || rdy[s+1]`, `rdy[NSTAGE] = out_ready`, `in_ready = rdy[0]`.
  - A stage loads when its own `rdy` is high.
  - Its valid becomes the upstream valid; the upstream valid for stage 0 is `in_valid`.
  - If not ready, the stage holds data and valid unchanged.
- `out_valid = v[NSTAGE-1]`. `sum`, `c_out` and `ovf` come straight from the final stage register.
- Bubbles collapse: an empty stage accepts even while downstream stalls.
- Order is strictly FIFO. Capacity is NSTAGE operations.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - all `v[s]` = 0
  - all data and carry registers = 0
  - `out_valid` = 0, `sum` = 0, `c_out` = 0, `ovf` = 0
  - `in_ready` = 1 while `out_ready` is either value, since the pipeline is empty
- Latency: result `out_valid` exactly NSTAGE rising edges after the accepting edge when `out_ready` is held high. Throughput is 1/cycle.
- `out_valid && !out_ready`: `sum`, `c_out` and `ovf` stay stable until accepted. This is an AXI-style rule: valid never drops without a handshake.
- Pipeline full and `out_ready=0`: `in_ready=0` in the same cycle.
- `out_ready` rising with a full pipeline: `in_ready=1` in the same cycle, a combinational path. Simultaneous accept and drain loses nothing.
- Reset mid-operation: all in-flight operations are discarded immediately, with no partial output.
- Wrap-around: the result is modulo 2^WIDTH; the carry out appears on `c_out`.

## Structure
- Shared package `adder_pkg`:
  - default `WIDTH`/`BLK`/`GPS`
  - function `nstage(width, blk, gps)`
  - elaboration check that `WIDTH % (BLK*GPS) == 0`
- Sub-module `cla_group`:
  - `BLK`-bit lookahead group, parametrised on `BLK`
  - outputs sum, group G, group P and carry into its MSB
  - instantiated `GPS` times per stage via generate
- Top-level `cla_pipe_adder` holds the stage registers, flow-control chain and mode conditioning.

## Test plan
- Default params (NSTAGE=4): `a=FFFFFFFF`, `b=00000001`, `c_in=0`, `sub=0` -> `sum=00000000`, `c_out=1`, `ovf=0`; `out_valid` 4 edges after accept.
- `sub=1`, `a=00000005`, `b=00000007`, `c_in=1` (ignored) -> `sum=FFFFFFFE`, `c_out=0`, `ovf=0`.
- `a=7FFFFFFF`, `b=00000001`, `sub=0` -> `sum=80000000`, `ovf=1`, `c_out=0`.
- Backpressure and ordering:
  - Stimulus: 8 back-to-back ops with a=i, b=i; `out_ready=0` for 3 cycles starting once the first result is valid.
  - Required: `in_ready=0` once 4 ops are in flight; results 0, 2, 4, ..., 14 arrive in order with none lost or duplicated; output held stable while stalled.
- Reset mid-stream: assert `rst_n` low with 3 ops in flight -> `out_valid=0` immediately; after release, `in_ready=1` and no stale result ever appears.
- Parameter sweep, random operands checked against a behavioural `+`:
  - `WIDTH=16, BLK=4, GPS=1` -> latency 4
  - `WIDTH=8, BLK=4, GPS=2` -> latency 1
  - `WIDTH=64, BLK=8, GPS=2` -> latency 4
